duck_pixel_pipe: RTL and testbench



---
 rtl/duck_pixel_pipe.sv | 189 ++++++++++++++++++
 tb/tb_duck_pixel_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duck_pixel_pipe.sv
// duck_pixel_pipe: drives the sprite index ROM and palette ROM, keeps pixel
// coordinates aligned with ROM data, applies transparency, and muxes the duck
// colour over the background into registered VGA RGB. It also resolves shots:
// it latches the cursor on a trigger, scans one full frame for an opaque duck
// pixel under the aim point, and then reports hit or miss.
// Optional build macro: CROSSHAIR_EN (white crosshair overlay at the cursor).
module duck_pixel_pipe #(
   parameter int IDX_W           = 4,
   parameter int TRANSPARENT_IDX = 0,
   parameter int LATENCY         = 4
`ifdef CROSSHAIR_EN
   ,
   parameter int CROSS_HALF      = 8
`endif
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_clk,
   input  logic [9:0]       DrawX,
   input  logic [9:0]       DrawY,
   input  logic             is_duck,
   input  logic [18:0]      duck_addr,
   output logic [18:0]      sprite_addr,
   input  logic [IDX_W-1:0] sprite_index,
   output logic [IDX_W-1:0] palette_addr,
   input  logic [23:0]      palette_rgb,
   input  logic [23:0]      bg_rgb,
   input  logic             trigger,
   input  logic [9:0]       CursorX,
   input  logic [9:0]       CursorY,
   output logic [7:0]       Red,
   output logic [7:0]       Green,
   output logic [7:0]       Blue,
   output logic             hit,
   output logic             shot_done
);

   localparam logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(TRANSPARENT_IDX);

   typedef enum logic [1:0] {IDLE, ARMED, SCAN, REPORT} shot_state_e;

   // Pixel pipeline state. Index 0 of the coordinate delay line is the input
   // sample stage; index LATENCY travels alongside the RGB output.
   logic                 duck0_q, v1_q, v2_q, opaque3_q, opaque4_q;
   logic [18:0]          addr0_q, sprite_addr_q;
   logic [IDX_W-1:0]     idx2_q, palette_addr_q;
   logic [9:0]           dx_q [LATENCY+1];
   logic [9:0]           dy_q [LATENCY+1];
   logic [23:0]          rgb_d, rgb_q;

   // Synchronisers (two flops) plus one extra flop for rising-edge detection.
   logic [2:0]           fr_sync_q, trig_sync_q;
   logic                 fr_edge, trig_edge;

   // Shot resolution state.
   shot_state_e          state_q;
   logic [9:0]           aim_x_q, aim_y_q;
   logic                 hit_seen_q, hit_q, shot_done_q;
   logic                 match;

   // Pixel pipeline: input sample, ROM address, index capture, palette address, RGB.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         duck0_q        <= 1'b0;
         addr0_q        <= '0;
         sprite_addr_q  <= '0;
         v1_q           <= 1'b0;
         idx2_q         <= '0;
         v2_q           <= 1'b0;
         palette_addr_q <= '0;
         opaque3_q      <= 1'b0;
         opaque4_q      <= 1'b0;
         rgb_q          <= '0;
         // NOTE: the coordinate delay line is a handful of flops, not a RAM, so
         // every element is cleared here; a real memory array would not be.
         for (int i = 0; i <= LATENCY; i++) begin
            dx_q[i] <= '0;
            dy_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage read the previous
         // value of its upstream register, which is what makes this a pipeline.
         duck0_q        <= is_duck;
         addr0_q        <= duck_addr;
         sprite_addr_q  <= duck0_q ? addr0_q : '0;
         v1_q           <= duck0_q;
         idx2_q         <= sprite_index;
         v2_q           <= v1_q;
         palette_addr_q <= idx2_q;
         opaque3_q      <= v2_q && (idx2_q != TRANSP_IDX);
         opaque4_q      <= opaque3_q;
         rgb_q          <= rgb_d;
         dx_q[0]        <= DrawX;
         dy_q[0]        <= DrawY;
         for (int i = 1; i <= LATENCY; i++) begin
            dx_q[i] <= dx_q[i-1];
            dy_q[i] <= dy_q[i-1];
         end
      end
   end

`ifdef CROSSHAIR_EN
   localparam logic [9:0] CROSS_W = 10'(CROSS_HALF);

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   logic cross_hit;
   assign cross_hit =
      ((dy_q[LATENCY-1] == CursorY) && (abs_diff(dx_q[LATENCY-1], CursorX) <= CROSS_W)) ||
      ((dx_q[LATENCY-1] == CursorX) && (abs_diff(dy_q[LATENCY-1], CursorY) <= CROSS_W));
`endif

   // Output colour: duck over background, optionally covered by the crosshair.
   always_comb begin
      // NOTE: assigning a value on every path before any condition keeps this
      // purely combinational; a missed branch would infer a latch.
      rgb_d = opaque3_q ? palette_rgb : bg_rgb;
`ifdef CROSSHAIR_EN
      if (cross_hit) rgb_d = 24'hFFFFFF;
`endif
   end

   // Bring frame strobe and fire button into the Clk domain.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fr_sync_q   <= '0;
         trig_sync_q <= '0;
      end else begin
         fr_sync_q   <= {fr_sync_q[1:0], frame_clk};
         trig_sync_q <= {trig_sync_q[1:0], trigger};
      end
   end

   assign fr_edge   = fr_sync_q[1] & ~fr_sync_q[2];
   assign trig_edge = trig_sync_q[1] & ~trig_sync_q[2];

   // An opaque duck pixel sitting exactly on the aim point at the output stage.
   assign match = opaque4_q && (dx_q[LATENCY] == aim_x_q) && (dy_q[LATENCY] == aim_y_q);

   // Shot FSM: arm on trigger, wait for a frame boundary, scan a full frame, report.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         aim_x_q     <= '0;
         aim_y_q     <= '0;
         hit_seen_q  <= 1'b0;
         hit_q       <= 1'b0;
         shot_done_q <= 1'b0;
      end else begin
         shot_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trig_edge) begin
                  aim_x_q    <= CursorX;
                  aim_y_q    <= CursorY;
                  hit_seen_q <= 1'b0;
                  state_q    <= ARMED;
               end
            end
            ARMED: begin
               if (fr_edge) state_q <= SCAN;
            end
            SCAN: begin
               if (match) hit_seen_q <= 1'b1;
               // A match coinciding with the closing frame edge still counts.
               if (fr_edge) begin
                  hit_q       <= hit_seen_q | match;
                  shot_done_q <= 1'b1;
                  state_q     <= REPORT;
               end
            end
            REPORT: begin
               // Result is already on the outputs; triggers here are dropped.
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sprite_addr          = sprite_addr_q;
   assign palette_addr         = palette_addr_q;
   assign {Red, Green, Blue}   = rgb_q;
   assign hit                  = hit_q;
   assign shot_done            = shot_done_q;

endmodule

// File: tb/tb_duck_pixel_pipe.sv
// tb_duck_pixel_pipe: scoreboard bench for duck_pixel_pipe. Behavioural ROMs
// answer the registered addresses; expected sprite_addr / palette_addr / RGB
// are queued when a pixel is driven and compared when they fall due. Shot
// resolution is exercised with hit, miss, ignored re-trigger and async reset.
module tb_duck_pixel_pipe;

   localparam logic [23:0] BG = 24'h3CBCFC;

   logic        clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic [9:0]  DrawX, DrawY;
   logic        is_duck;
   logic [18:0] duck_addr;
   logic [18:0] sprite_addr;
   logic [3:0]  sprite_index;
   logic [3:0]  palette_addr;
   logic [23:0] palette_rgb;
   logic [23:0] bg_rgb;
   logic        trigger;
   logic [9:0]  CursorX, CursorY;
   logic [7:0]  Red, Green, Blue;
   logic        hit, shot_done;
   logic [23:0] rgb_o;

   always #5 clk = ~clk;

   duck_pixel_pipe dut (
      .Clk          (clk),
      .Reset        (Reset),
      .frame_clk    (frame_clk),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .is_duck      (is_duck),
      .duck_addr    (duck_addr),
      .sprite_addr  (sprite_addr),
      .sprite_index (sprite_index),
      .palette_addr (palette_addr),
      .palette_rgb  (palette_rgb),
      .bg_rgb       (bg_rgb),
      .trigger      (trigger),
      .CursorX      (CursorX),
      .CursorY      (CursorY),
      .Red          (Red),
      .Green        (Green),
      .Blue         (Blue),
      .hit          (hit),
      .shot_done    (shot_done)
   );

   assign rgb_o = {Red, Green, Blue};

   // Sprite ROM contents: index = low nibble + next nibble (0x123 -> 5, 0xF1 -> 0).
   function automatic logic [3:0] rom_idx(input logic [18:0] a);
      return a[3:0] + a[7:4];
   endfunction

   // Palette ROM contents; entry 5 is the colour named in the plan.
   function automatic logic [23:0] pal(input logic [3:0] i);
      if (i == 4'd5) return 24'h112233;
      return {i, 4'h8, ~i, 4'h1, 4'h3, i};
   endfunction

`ifdef CROSSHAIR_EN
   function automatic bit in_cross(input int x, input int y, input int cx, input int cy);
      int ax, ay;
      ax = (x > cx) ? x - cx : cx - x;
      ay = (y > cy) ? y - cy : cy - y;
      return ((y == cy) && (ax <= 8)) || ((x == cx) && (ay <= 8));
   endfunction
`endif

   // The address registers are the ROMs' one cycle of read latency.
   assign sprite_index = rom_idx(sprite_addr);
   assign palette_rgb  = pal(palette_addr);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          due;
      logic [31:0] val;
   } exp_t;

   exp_t q_sa[$];
   exp_t q_pa[$];
   exp_t q_rgb[$];

   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = -100;
   int frame_rise_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Compare every queued expectation in the cycle it falls due.
   always @(negedge clk) begin
      exp_t e;
      while (q_sa.size() > 0 && q_sa[0].due <= cyc) begin
         e = q_sa.pop_front();
         check("sprite_addr", 32'(sprite_addr), e.val);
      end
      while (q_pa.size() > 0 && q_pa[0].due <= cyc) begin
         e = q_pa.pop_front();
         check("palette_addr", 32'(palette_addr), e.val);
      end
      while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
         e = q_rgb.pop_front();
         check("rgb", 32'(rgb_o), e.val);
      end
   end

   always @(negedge clk) begin
      if (shot_done === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
   end

   task automatic idle();
      @(posedge clk); #1;
      is_duck   = 1'b0;
      duck_addr = '0;
      DrawX     = '0;
      DrawY     = '0;
   endtask

   task automatic drain();
      repeat (6) idle();
   endtask

   // Drive one pixel and queue what the pipeline must produce for it.
   task automatic drive_pixel(input logic duck, input logic [18:0] addr,
                              input logic [9:0] x, input logic [9:0] y);
      exp_t        e;
      logic [18:0] sa;
      logic [3:0]  idx;
      logic [23:0] rgb;
      int          ed;
      @(posedge clk); #1;
      is_duck   = duck;
      duck_addr = addr;
      DrawX     = x;
      DrawY     = y;
      ed  = cyc + 1;
      sa  = duck ? addr : 19'd0;
      idx = rom_idx(sa);
      rgb = (duck && idx != 4'd0) ? pal(idx) : BG;
`ifdef CROSSHAIR_EN
      if (in_cross(int'(x), int'(y), int'(CursorX), int'(CursorY))) rgb = 24'hFFFFFF;
`endif
      e.due = ed + 1; e.val = 32'(sa);  q_sa.push_back(e);
      e.due = ed + 3; e.val = 32'(idx); q_pa.push_back(e);
      e.due = ed + 4; e.val = 32'(rgb); q_rgb.push_back(e);
   endtask

   task automatic frame_pulse();
      @(posedge clk); #1;
      frame_clk      = 1'b1;
      frame_rise_cyc = cyc;
      repeat (4) @(posedge clk);
      #1 frame_clk = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic trig_pulse();
      @(posedge clk); #1 trigger = 1'b1;
      repeat (4) @(posedge clk);
      #1 trigger = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   // Closing frame of a shot: exactly one shot_done, three clocks after the
   // raw frame strobe rises (2 sync flops + edge detect + report), and the hit.
   task automatic finish_shot(input string tag, input logic exp_hit);
      int start;
      start = done_cnt;
      frame_pulse();
      repeat (12) @(negedge clk);
      #1;
      check({tag, "_shot_count"}, 32'(done_cnt - start), 32'd1);
      check({tag, "_shot_latency"}, 32'(last_done_cyc - frame_rise_cyc), 32'd3);
      check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int start;
      Reset     = 1'b1;
      frame_clk = 1'b0;
      trigger   = 1'b0;
      is_duck   = 1'b0;
      duck_addr = '0;
      DrawX     = '0;
      DrawY     = '0;
      bg_rgb    = BG;
      CursorX   = 10'd900;
      CursorY   = 10'd900;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_sprite_addr", 32'(sprite_addr), 32'd0);
      check("rst_palette_addr", 32'(palette_addr), 32'd0);
      check("rst_rgb", 32'(rgb_o), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_shot_done", 32'(shot_done), 32'd0);
      @(posedge clk); #1 Reset = 1'b0;
      drain();

      // Latency: opaque index 5 -> 0x112233 four clocks after sampling.
      drive_pixel(1'b1, 19'h00123, 10'd50, 10'd60);
      drain();

      // Transparency and out-of-box pixels fall through to the background.
      drive_pixel(1'b1, 19'h000F1, 10'd51, 10'd60);
      drive_pixel(1'b0, 19'h00777, 10'd52, 10'd60);
      drive_pixel(1'b1, 19'h00123, 10'd53, 10'd60);
      drain();

      // Back-to-back random pixels: one accepted per clock, no bubbles.
      for (int i = 0; i < 40; i++)
         drive_pixel(1'($urandom_range(0, 1)), 19'($urandom),
                     10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
      drain();

      // Crosshair arm ends at +8 pixels; +9 is background (without the macro
      // every one of these is background).
      CursorX = 10'd100;
      CursorY = 10'd100;
      drive_pixel(1'b0, 19'd0, 10'd108, 10'd100);
      drive_pixel(1'b0, 19'd0, 10'd109, 10'd100);
      drive_pixel(1'b0, 19'd0, 10'd100, 10'd92);
      drive_pixel(1'b0, 19'd0, 10'd100, 10'd91);
      drive_pixel(1'b1, 19'h00123, 10'd100, 10'd100);
      drain();

      // Hit: aim (330,250); moving the cursor afterwards must not matter.
      CursorX = 10'd330;
      CursorY = 10'd250;
      trig_pulse();
      CursorX = 10'd20;
      CursorY = 10'd20;
      frame_pulse();
      drive_pixel(1'b1, 19'h00123, 10'd330, 10'd250);
      drain();
      finish_shot("hit", 1'b1);

      // Miss: transparent pixel on the aim point, opaque neighbour beside it,
      // and a second trigger inside SCAN that must be ignored.
      CursorX = 10'd330;
      CursorY = 10'd250;
      trig_pulse();
      check("hit_held", 32'(hit), 32'd1);
      CursorX = 10'd20;
      CursorY = 10'd20;
      frame_pulse();
      drive_pixel(1'b1, 19'h000F1, 10'd330, 10'd250);
      drive_pixel(1'b1, 19'h00123, 10'd331, 10'd250);
      drain();
      trig_pulse();
      finish_shot("miss", 1'b0);

      // Set up a remembered hit, then reset in the middle of a scan.
      CursorX = 10'd330;
      CursorY = 10'd250;
      trig_pulse();
      frame_pulse();
      drive_pixel(1'b1, 19'h00123, 10'd330, 10'd250);
      drain();
      finish_shot("pre_reset", 1'b1);
      trig_pulse();
      frame_pulse();
      repeat (6) drive_pixel(1'b1, 19'h00123, 10'd5, 10'd5);
      #2;
      Reset = 1'b1;
      q_sa.delete();
      q_pa.delete();
      q_rgb.delete();
      #1;
      check("async_rst_sprite_addr", 32'(sprite_addr), 32'd0);
      check("async_rst_palette_addr", 32'(palette_addr), 32'd0);
      check("async_rst_rgb", 32'(rgb_o), 32'd0);
      check("async_rst_hit", 32'(hit), 32'd0);
      check("async_rst_shot_done", 32'(shot_done), 32'd0);
      repeat (3) @(posedge clk);
      #1 Reset = 1'b0;
      idle();

      // After reset the FSM is idle: frames alone produce no shot.
      start = done_cnt;
      frame_pulse();
      frame_pulse();
      repeat (20) @(negedge clk);
      #1;
      check("post_rst_no_shot", 32'(done_cnt - start), 32'd0);
      check("post_rst_hit", 32'(hit), 32'd0);

      // A fresh shot still works from IDLE (nothing under the aim point).
      trig_pulse();
      frame_pulse();
      drain();
      finish_shot("post_rst_shot", 1'b0);

      drain();
      check("scoreboard_drained", 32'(q_sa.size() + q_pa.size() + q_rgb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
